// File: rtl/vlsu_pkg.sv
// Shared definitions for the vector load/store unit: AXI burst encodings,
// page geometry and the transaction-control record passed to the load unit.
package vlsu_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam int unsigned PAGE_BYTES     = 4096;
    localparam int unsigned PAGE_BITS      = 12;

    localparam int unsigned DEF_AXI_DATA_WIDTH = 128;
    localparam int unsigned TXN_OFF_WIDTH      = $clog2(DEF_AXI_DATA_WIDTH / 8);
    localparam int unsigned TXN_NBYTES_WIDTH   = 13;

    typedef struct packed {
        logic [TXN_OFF_WIDTH-1:0]    offset;
        logic [TXN_NBYTES_WIDTH-1:0] nbytes;
        logic                        last;
    } txn_ctrl_t;

    typedef enum logic {
        LAG_IDLE  = 1'b0,
        LAG_ISSUE = 1'b1
    } lag_state_t;

endpackage

// File: rtl/load_addr_gen_burst_calc.sv
// Combinational burst sizing: from the current page offset and remaining bytes,
// derive the bytes carried by the next burst and the beats it needs.
module burst_calc
    import vlsu_pkg::*;
#(
    parameter int unsigned B           = 16,
    parameter int unsigned MaxBurstLen = 256,
    parameter int unsigned LenWidth    = 16
) (
    input  logic [PAGE_BITS-1:0]  i_page_addr,
    input  logic [LenWidth-1:0]   i_rem,
    output logic [12:0]           o_chunk,
    output logic [8:0]            o_beats,
    output logic [$clog2(B)-1:0]  o_off,
    output logic                  o_last
);
    localparam int unsigned OffW     = $clog2(B);
    // A burst can never carry more than a page, so cap the burst byte limit there.
    localparam int unsigned MaxBytes = (MaxBurstLen * B > PAGE_BYTES) ? PAGE_BYTES : MaxBurstLen * B;

    logic [12:0] w_to4k;
    logic [12:0] w_maxb;
    logic [12:0] w_lim;
    logic [12:0] w_chunk;
    logic [13:0] w_span;
    logic [13:0] w_beats;

    always_comb begin
        w_to4k  = 13'(PAGE_BYTES) - {1'b0, i_page_addr};
        w_maxb  = 13'(MaxBytes) - 13'(i_page_addr[OffW-1:0]);
        w_lim   = (w_maxb < w_to4k) ? w_maxb : w_to4k;
        w_chunk = (32'(i_rem) > 32'(w_lim)) ? w_lim : 13'(i_rem);
        w_span  = 14'(i_page_addr[OffW-1:0]) + 14'(w_chunk) + 14'(B - 1);
        w_beats = w_span >> OffW;
    end

    assign o_chunk = w_chunk;
    assign o_beats = 9'(w_beats);
    assign o_off   = i_page_addr[OffW-1:0];
    assign o_last  = (32'(i_rem) == 32'(w_chunk));

endmodule

// File: rtl/load_addr_gen.sv
// Splits a unit-stride vector load into 4 KiB-safe AXI INCR read bursts and
// emits one AR beat plus one matching transaction-control record per burst.
module load_addr_gen
    import vlsu_pkg::*;
#(
    parameter int unsigned AxiDataWidth = 128,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned MaxBurstLen  = 256,
    parameter int unsigned LenWidth     = 16,
    localparam int unsigned B           = AxiDataWidth / 8,
    localparam int unsigned OffW        = $clog2(B)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AxiAddrWidth-1:0] req_addr_i,
    input  logic [LenWidth-1:0]     req_nbytes_i,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    output logic [AxiAddrWidth-1:0] ar_addr_o,
    output logic [7:0]              ar_len_o,
    output logic [2:0]              ar_size_o,
    output logic [1:0]              ar_burst_o,
    output logic                    txn_valid_o,
    input  logic                    txn_ready_i,
    output logic [OffW-1:0]         txn_offset_o,
    output logic [12:0]             txn_nbytes_o,
    output logic                    txn_last_o,
    output lag_state_t              dbg_state_o
);
    // Handshake rule on every channel: a transfer happens on a rising edge where
    // valid and ready are both high; once valid rises, it and its payload hold
    // until that edge, and valid never depends on ready.

    lag_state_t              r_state, w_state_nxt;
    logic [AxiAddrWidth-1:0] r_cur_addr, w_cur_addr_nxt;
    logic [LenWidth-1:0]     r_rem, w_rem_nxt;
    logic                    r_ar_done, w_ar_done_nxt;
    logic                    r_txn_done, w_txn_done_nxt;

    logic [12:0]             w_chunk;
    logic [8:0]              w_beats;
    logic [OffW-1:0]         w_off;
    logic                    w_last;
    logic                    w_issue;
    logic                    w_ar_ok;
    logic                    w_txn_ok;

    burst_calc #(
        .B           (B),
        .MaxBurstLen (MaxBurstLen),
        .LenWidth    (LenWidth)
    ) u_burst_calc (
        .i_page_addr (r_cur_addr[PAGE_BITS-1:0]),
        .i_rem       (r_rem),
        .o_chunk     (w_chunk),
        .o_beats     (w_beats),
        .o_off       (w_off),
        .o_last      (w_last)
    );

    assign w_issue  = (r_state == LAG_ISSUE);
    assign w_ar_ok  = r_ar_done  | (ar_valid_o  & ar_ready_i);
    assign w_txn_ok = r_txn_done | (txn_valid_o & txn_ready_i);

    // Payload is a pure function of registers, so it holds while a side stalls.
    assign req_ready_o  = (r_state == LAG_IDLE);
    assign ar_valid_o   = w_issue & ~r_ar_done;
    assign txn_valid_o  = w_issue & ~r_txn_done;
    assign ar_addr_o    = w_issue ? {r_cur_addr[AxiAddrWidth-1:OffW], {OffW{1'b0}}} : '0;
    assign ar_len_o     = w_issue ? 8'(w_beats - 9'd1) : 8'd0;
    assign ar_size_o    = 3'(OffW);
    assign ar_burst_o   = AXI_BURST_INCR;
    assign txn_offset_o = w_issue ? w_off : '0;
    assign txn_nbytes_o = w_issue ? w_chunk : 13'd0;
    assign txn_last_o   = w_issue & w_last;
    assign dbg_state_o  = r_state;

    always_comb begin
        w_state_nxt    = r_state;
        w_cur_addr_nxt = r_cur_addr;
        w_rem_nxt      = r_rem;
        w_ar_done_nxt  = r_ar_done;
        w_txn_done_nxt = r_txn_done;
        case (r_state)
            LAG_IDLE: begin
                if (req_valid_i && (req_nbytes_i != '0)) begin
                    w_cur_addr_nxt = req_addr_i;
                    w_rem_nxt      = req_nbytes_i;
                    w_state_nxt    = LAG_ISSUE;
                end
            end
            LAG_ISSUE: begin
                if (w_ar_ok && w_txn_ok) begin
                    w_ar_done_nxt  = 1'b0;
                    w_txn_done_nxt = 1'b0;
                    w_cur_addr_nxt = r_cur_addr + AxiAddrWidth'(w_chunk);
                    w_rem_nxt      = r_rem - LenWidth'(w_chunk);
                    if (w_last) begin
                        w_state_nxt = LAG_IDLE;
                    end
                end else begin
                    w_ar_done_nxt  = w_ar_ok;
                    w_txn_done_nxt = w_txn_ok;
                end
            end
            default: w_state_nxt = LAG_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= LAG_IDLE;
            r_cur_addr <= '0;
            r_rem      <= '0;
            r_ar_done  <= 1'b0;
            r_txn_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_addr <= w_cur_addr_nxt;
            r_rem      <= w_rem_nxt;
            r_ar_done  <= w_ar_done_nxt;
            r_txn_done <= w_txn_done_nxt;
        end
    end

endmodule

// File: tb/tb_load_addr_gen.sv
// Directed bench for load_addr_gen and its burst_calc helper, B = 16 and
// MaxBurstLen = 256, with hand-computed expected burst records.
module tb_load_addr_gen;
    import vlsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [15:0] req_nbytes;
    logic        ar_valid;
    logic        ar_ready;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        txn_valid;
    logic        txn_ready;
    logic [3:0]  txn_offset;
    logic [12:0] txn_nbytes;
    logic        txn_last;
    lag_state_t  dbg_state;

    logic [11:0] bc_page;
    logic [15:0] bc_rem;
    logic [12:0] bc_chunk;
    logic [8:0]  bc_beats;
    logic [3:0]  bc_off;
    logic        bc_last;

    int checks = 0;
    int errors = 0;
    int ar_hs  = 0;
    int txn_hs = 0;

    load_addr_gen #(
        .AxiDataWidth (128),
        .AxiAddrWidth (64),
        .MaxBurstLen  (256),
        .LenWidth     (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_nbytes_i (req_nbytes),
        .ar_valid_o   (ar_valid),
        .ar_ready_i   (ar_ready),
        .ar_addr_o    (ar_addr),
        .ar_len_o     (ar_len),
        .ar_size_o    (ar_size),
        .ar_burst_o   (ar_burst),
        .txn_valid_o  (txn_valid),
        .txn_ready_i  (txn_ready),
        .txn_offset_o (txn_offset),
        .txn_nbytes_o (txn_nbytes),
        .txn_last_o   (txn_last),
        .dbg_state_o  (dbg_state)
    );

    burst_calc #(
        .B           (16),
        .MaxBurstLen (256),
        .LenWidth    (16)
    ) u_calc (
        .i_page_addr (bc_page),
        .i_rem       (bc_rem),
        .o_chunk     (bc_chunk),
        .o_beats     (bc_beats),
        .o_off       (bc_off),
        .o_last      (bc_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ar_valid && ar_ready)   ar_hs  <= ar_hs + 1;
        if (txn_valid && txn_ready) txn_hs <= txn_hs + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [63:0] addr, input logic [15:0] nbytes);
        check("req_ready_before_req", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_nbytes = nbytes;
        step();
        req_valid  = 1'b0;
    endtask

    task automatic expect_burst(input string tag, input logic [63:0] addr, input logic [7:0] len,
                                input logic [3:0] off, input logic [12:0] nb, input logic last);
        check({tag, "_ar_valid"},  64'(ar_valid),   64'd1);
        check({tag, "_txn_valid"}, 64'(txn_valid),  64'd1);
        check({tag, "_ar_addr"},   ar_addr,         addr);
        check({tag, "_ar_len"},    64'(ar_len),     64'(len));
        check({tag, "_txn_off"},   64'(txn_offset), 64'(off));
        check({tag, "_txn_nb"},    64'(txn_nbytes), 64'(nb));
        check({tag, "_txn_last"},  64'(txn_last),   64'(last));
        check({tag, "_req_ready"}, 64'(req_ready),  64'd0);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_ar_valid"},  64'(ar_valid),  64'd0);
        check({tag, "_txn_valid"}, 64'(txn_valid), 64'd0);
    endtask

    task automatic calc_vec(input string tag, input logic [11:0] page, input logic [15:0] rem,
                            input logic [12:0] chunk, input logic [8:0] beats,
                            input logic [3:0] off, input logic last);
        bc_page = page;
        bc_rem  = rem;
        #1;
        check({tag, "_chunk"}, 64'(bc_chunk), 64'(chunk));
        check({tag, "_beats"}, 64'(bc_beats), 64'(beats));
        check({tag, "_off"},   64'(bc_off),   64'(off));
        check({tag, "_last"},  64'(bc_last),  64'(last));
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_nbytes = '0;
        ar_ready   = 1'b1;
        txn_ready  = 1'b1;
        bc_page    = '0;
        bc_rem     = '0;

        // Standalone burst sizing.
        calc_vec("calc_cross4k", 12'hFF8, 16'd16,   13'd8,    9'd1,   4'd8, 1'b0);
        calc_vec("calc_maxb",    12'h003, 16'd5000, 13'd4093, 9'd256, 4'd3, 1'b0);
        calc_vec("calc_unalign", 12'h005, 16'd32,   13'd32,   9'd3,   4'd5, 1'b1);

        // Reset values.
        step();
        step();
        expect_idle("reset");
        check("reset_ar_addr",  ar_addr,            64'd0);
        check("reset_ar_len",   64'(ar_len),        64'd0);
        check("reset_ar_size",  64'(ar_size),       64'd4);
        check("reset_ar_burst", 64'(ar_burst),      64'd1);
        check("reset_txn_off",  64'(txn_offset),    64'd0);
        check("reset_txn_nb",   64'(txn_nbytes),    64'd0);
        check("reset_txn_last", 64'(txn_last),      64'd0);
        rst = 1'b0;
        step();

        // Aligned request.
        send_req(64'h1000, 16'd64);
        expect_burst("aligned", 64'h1000, 8'd3, 4'd0, 13'd64, 1'b1);
        check("aligned_size",  64'(ar_size),  64'd4);
        check("aligned_burst", 64'(ar_burst), 64'd1);
        step();
        expect_idle("aligned_done");
        step();

        // Unaligned request.
        send_req(64'h1005, 16'd32);
        expect_burst("unaligned", 64'h1000, 8'd2, 4'd5, 13'd32, 1'b1);
        step();
        expect_idle("unaligned_done");
        step();

        // 4 KiB crossing.
        send_req(64'h0FF8, 16'd16);
        expect_burst("cross_b0", 64'h0FF0, 8'd0, 4'd8, 13'd8, 1'b0);
        step();
        expect_burst("cross_b1", 64'h1000, 8'd0, 4'd0, 13'd8, 1'b1);
        step();
        expect_idle("cross_done");
        step();

        // Long request, bursts in consecutive cycles.
        send_req(64'h0, 16'd8192);
        expect_burst("long_b0", 64'h0000, 8'd255, 4'd0, 13'd4096, 1'b0);
        step();
        expect_burst("long_b1", 64'h1000, 8'd255, 4'd0, 13'd4096, 1'b1);
        step();
        expect_idle("long_done");
        step();

        // Backpressure on AR only.
        ar_ready = 1'b0;
        ar_hs    = 0;
        txn_hs   = 0;
        send_req(64'h2000, 16'd48);
        expect_burst("bp_first", 64'h2000, 8'd2, 4'd0, 13'd48, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_ar_valid",  64'(ar_valid),  64'd1);
            check("bp_txn_valid", 64'(txn_valid), 64'd0);
            check("bp_ar_addr",   ar_addr,        64'h2000);
            check("bp_ar_len",    64'(ar_len),    64'd2);
        end
        step();
        ar_ready = 1'b1;
        check("bp_ar_addr_release", ar_addr, 64'h2000);
        step();
        expect_idle("bp_done");
        check("bp_ar_hs",  64'(ar_hs),  64'd1);
        check("bp_txn_hs", 64'(txn_hs), 64'd1);
        step();

        // Zero-byte request.
        send_req(64'h3000, 16'd0);
        expect_idle("zero_t1");
        step();
        expect_idle("zero_t2");

        // Reset in the middle of a 3-burst request.
        send_req(64'h0FF8, 16'd4200);
        expect_burst("rst_b0", 64'h0FF0, 8'd0, 4'd8, 13'd8, 1'b0);
        step();
        expect_burst("rst_b1", 64'h1000, 8'd255, 4'd0, 13'd4096, 1'b0);
        rst = 1'b1;
        #1;
        expect_idle("rst_abort");
        check("rst_abort_ar_addr", ar_addr, 64'd0);
        step();
        rst = 1'b0;
        step();
        send_req(64'h1000, 16'd64);
        expect_burst("post_rst", 64'h1000, 8'd3, 4'd0, 13'd64, 1'b1);
        step();
        expect_idle("post_rst_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
